// File: rtl/fb_pkg.sv
// Shared types and geometry for the framebuffer responder.
package fb_pkg;

  localparam int unsigned FB_COLS   = 80;
  localparam int unsigned FB_ROWS   = 60;
  localparam int unsigned FB_CELLS  = FB_COLS * FB_ROWS;
  localparam int unsigned FB_ADDR_W = 15;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } fb_wr_t;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  // True when a cell address falls inside the 80x60 framebuffer.
  function automatic logic fb_in_range(input logic [FB_ADDR_W-1:0] a);
    return a < FB_ADDR_W'(FB_CELLS);
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering CPU cell writes until the memory port is free.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int unsigned WR_DEPTH = 4
) (
  input  logic   clk_pixel,
  input  logic   reset,
  input  logic   push,
  input  fb_wr_t push_data,
  input  logic   pop,
  output fb_wr_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(WR_DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  fb_wr_t      mem_q [WR_DEPTH];
  logic        do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; a reset discards any queued entries.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, not reset.
  always_ff @(posedge clk_pixel) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fb_responder.sv
// Framebuffer responder: scan-out reads, buffered CPU writes and a clear engine
// sharing one memory port, with scan-out always taking priority.
module fb_responder
  import fb_pkg::*;
#(
  parameter int unsigned WR_DEPTH    = 4,
  parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [14:0] vga_data_addr,
  input  logic        in_display_area,
  output logic [7:0]  vga_cell,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        err_oob
);

  clr_state_t  state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic        err_oob_q, err_oob_d;
  logic        rd_ok_q, rd_ok_d;
  logic [7:0]  rd_data_q;
  logic [7:0]  mem_q [FB_CELLS];

  fb_wr_t      fifo_head;
  logic        fifo_full, fifo_empty;
  logic        rd_gnt, clr_gnt, fifo_gnt;
  logic        mem_we;
  logic [12:0] mem_idx;
  logic [7:0]  mem_wdata;

  fb_wr_fifo #(
    .WR_DEPTH (WR_DEPTH)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .push      (wr_valid),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_gnt),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_ready   = !fifo_full;
  assign clear_busy = (state_q == CLR_RUN);
  assign err_oob    = err_oob_q;
  assign vga_cell   = rd_ok_q ? rd_data_q : 8'h00;

  // Port arbitration and the single shared address/data mux.
  always_comb begin
    rd_gnt    = in_display_area;
    clr_gnt   = !in_display_area && clear_busy;
    fifo_gnt  = !in_display_area && !clear_busy && !fifo_empty;
    mem_idx   = fifo_head.addr[12:0];
    mem_wdata = fifo_head.data;
    mem_we    = fifo_gnt && fb_in_range(fifo_head.addr);
    if (rd_gnt) begin
      mem_idx = vga_data_addr[12:0];
      mem_we  = 1'b0;
    end else if (clr_gnt) begin
      mem_idx   = clr_addr_q[12:0];
      mem_wdata = CLEAR_VALUE;
      mem_we    = 1'b1;
    end
  end

  // Clear engine, out-of-bounds flag and read-valid next-state.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    err_oob_d  = err_oob_q;
    rd_ok_d    = rd_gnt && fb_in_range(vga_data_addr);
    if (fifo_gnt && !fb_in_range(fifo_head.addr)) err_oob_d = 1'b1;
    unique case (state_q)
      CLR_IDLE: begin
        if (clear_req) begin
          state_d    = CLR_RUN;
          clr_addr_d = '0;
        end
      end
      CLR_RUN: begin
        if (clr_gnt) begin
          if (clr_addr_q == 15'(FB_CELLS - 1)) state_d = CLR_IDLE;
          else clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q    <= CLR_IDLE;
      clr_addr_q <= '0;
      err_oob_q  <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      err_oob_q  <= err_oob_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  // Video memory: one registered read or one write per cycle, contents not reset.
  always_ff @(posedge clk_pixel) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
    if (rd_gnt) rd_data_q <= mem_q[mem_idx];
  end

endmodule

// File: tb/tb_fb_responder.sv
// Directed bench for fb_responder: vector table plus multi-cycle sequences.
module tb_fb_responder;

  logic        clk;
  logic        reset;
  logic [14:0] vga_data_addr;
  logic        in_display_area;
  logic [7:0]  vga_cell;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        clear_req;
  logic        clear_busy;
  logic        err_oob;

  int checks = 0;
  int errors = 0;

  fb_responder #(
    .WR_DEPTH    (4),
    .CLEAR_VALUE (8'h00)
  ) dut (
    .clk_pixel       (clk),
    .reset           (reset),
    .vga_data_addr   (vga_data_addr),
    .in_display_area (in_display_area),
    .vga_cell        (vga_cell),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .clear_req       (clear_req),
    .clear_busy      (clear_busy),
    .err_oob         (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        disp;
    logic [14:0] raddr;
    logic        wv;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic [7:0]  e_cell;
    logic        e_ready;
    logic        e_busy;
    logic        e_oob;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic disp, input logic [14:0] raddr, input logic wv,
                      input logic [14:0] wa, input logic [7:0] wd, input logic clr,
                      input logic rst);
    @(negedge clk);
    in_display_area = disp;
    vga_data_addr   = raddr;
    wr_valid        = wv;
    wr_addr         = wa;
    wr_data         = wd;
    clear_req       = clr;
    reset           = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 15'd0, 1'b0, 15'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [14:0] a, input logic [7:0] d);
    step(1'b0, 15'd0, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic read_chk(input string name, input logic [14:0] a, input logic [7:0] exp);
    step(1'b1, a, 1'b0, 15'd0, 8'h00, 1'b0, 1'b0);
    chk(name, {24'd0, vga_cell}, {24'd0, exp});
  endtask

  initial begin
    int busy_cnt;
    int cyc;
    int bad;
    logic [7:0] exp8;

    //          disp raddr     wv  wa         wd     cell   rdy  busy oob
    vecs[0]  = '{1'b0, 15'd0,    1'b0, 15'd0,    8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 15'd0,    1'b1, 15'd81,   8'hA5, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 15'd0,    1'b0, 15'd0,    8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 15'd81,   1'b0, 15'd0,    8'h00, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 15'd5000, 1'b0, 15'd0,    8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 15'd0,    1'b1, 15'd82,   8'h5A, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 15'd81,   1'b0, 15'd0,    8'h00, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 15'd0,    1'b0, 15'd0,    8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 15'd82,   1'b0, 15'd0,    8'h00, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 15'd0,    1'b1, 15'd4800, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 15'd0,    1'b0, 15'd0,    8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 15'd81,   1'b0, 15'd0,    8'h00, 8'hA5, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 15'd4800, 1'b0, 15'd0,    8'h00, 8'h00, 1'b1, 1'b0, 1'b1};

    in_display_area = 1'b0;
    vga_data_addr   = '0;
    wr_valid        = 1'b0;
    wr_addr         = '0;
    wr_data         = '0;
    clear_req       = 1'b0;
    reset           = 1'b1;

    // Reset state.
    step(1'b0, 15'd0, 1'b0, 15'd0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 15'd0, 1'b0, 15'd0, 8'h00, 1'b0, 1'b1);
    chk("rst_vga_cell", {24'd0, vga_cell}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
    chk("rst_err_oob", {31'd0, err_oob}, 32'd0);

    // Vector table: basic read/write, OOB read, OOB write flag.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].disp, vecs[i].raddr, vecs[i].wv, vecs[i].wa, vecs[i].wd, 1'b0, 1'b0);
      chk($sformatf("vec%0d_cell", i), {24'd0, vga_cell}, {24'd0, vecs[i].e_cell});
      chk($sformatf("vec%0d_ready", i), {31'd0, wr_ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d_busy", i), {31'd0, clear_busy}, {31'd0, vecs[i].e_busy});
      chk($sformatf("vec%0d_oob", i), {31'd0, err_oob}, {31'd0, vecs[i].e_oob});
    end

    // FIFO fills while scan-out owns the port, then drains in order.
    for (int a = 100; a <= 105; a++) push(15'(a), 8'hEE);
    idle();
    idle();
    step(1'b1, 15'd100, 1'b1, 15'd100, 8'h10, 1'b0, 1'b0);
    step(1'b1, 15'd100, 1'b1, 15'd101, 8'h11, 1'b0, 1'b0);
    step(1'b1, 15'd100, 1'b1, 15'd102, 8'h12, 1'b0, 1'b0);
    chk("full_ready_after3", {31'd0, wr_ready}, 32'd1);
    step(1'b1, 15'd100, 1'b1, 15'd103, 8'h13, 1'b0, 1'b0);
    chk("full_ready_after4", {31'd0, wr_ready}, 32'd0);
    chk("full_no_mem_change", {24'd0, vga_cell}, 32'hEE);
    step(1'b1, 15'd100, 1'b1, 15'd104, 8'h14, 1'b0, 1'b0);
    chk("full_rejects_5th", {31'd0, wr_ready}, 32'd0);
    idle();
    chk("drain_ready_rises", {31'd0, wr_ready}, 32'd1);
    push(15'd103, 8'h31);  // push and pop together; newer 103 must win
    idle();
    idle();
    idle();
    idle();
    read_chk("fifo_100", 15'd100, 8'h10);
    read_chk("fifo_101", 15'd101, 8'h11);
    read_chk("fifo_102", 15'd102, 8'h12);
    read_chk("fifo_order_103", 15'd103, 8'h31);
    read_chk("fifo_rejected_104", 15'd104, 8'hEE);

    // Fill with FF, then clear; a write queued during the clear must survive it.
    for (int a = 0; a < 4800; a++) push(15'(a), 8'hFF);
    idle();
    read_chk("fill_2000", 15'd2000, 8'hFF);
    step(1'b0, 15'd0, 1'b0, 15'd0, 8'h00, 1'b1, 1'b0);
    busy_cnt = clear_busy ? 1 : 0;
    cyc = 0;
    while (clear_busy && cyc < 6000) begin
      cyc++;
      if (cyc == 1) push(15'd4799, 8'h3C);
      else if (cyc == 2000) step(1'b0, 15'd0, 1'b0, 15'd0, 8'h00, 1'b1, 1'b0);
      else idle();
      if (clear_busy) busy_cnt++;
    end
    chk("clear_busy_cycles", busy_cnt, 32'd4800);
    chk("clear_finished", {31'd0, clear_busy}, 32'd0);
    idle();
    bad = 0;
    for (int a = 0; a < 4800; a++) begin
      step(1'b1, 15'(a), 1'b0, 15'd0, 8'h00, 1'b0, 1'b0);
      exp8 = (a == 4799) ? 8'h3C : 8'h00;
      if (vga_cell !== exp8) bad++;
    end
    chk("clear_bad_cells", bad, 32'd0);
    read_chk("clear_4799_kept", 15'd4799, 8'h3C);
    read_chk("clear_4798", 15'd4798, 8'h00);
    chk("oob_sticky", {31'd0, err_oob}, 32'd1);

    // Reset in mid-clear with queued writes.
    push(15'd50, 8'h22);
    push(15'd200, 8'h22);
    push(15'd4000, 8'h11);
    push(15'd4001, 8'h11);
    push(15'd4002, 8'h11);
    idle();
    step(1'b0, 15'd0, 1'b0, 15'd0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      if (k < 3) push(15'(4000 + k), 8'h99);
      else idle();
    end
    step(1'b0, 15'd0, 1'b0, 15'd0, 8'h00, 1'b0, 1'b1);
    chk("mid_rst_busy", {31'd0, clear_busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, wr_ready}, 32'd1);
    chk("mid_rst_oob", {31'd0, err_oob}, 32'd0);
    for (int k = 0; k < 5; k++) idle();
    chk("post_rst_busy", {31'd0, clear_busy}, 32'd0);
    read_chk("partial_clear_50", 15'd50, 8'h00);
    read_chk("partial_clear_200", 15'd200, 8'h22);
    read_chk("lost_write_4000", 15'd4000, 8'h11);
    read_chk("lost_write_4001", 15'd4001, 8'h11);
    read_chk("lost_write_4002", 15'd4002, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
